// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle (AW, W, AR, R channels; no B channel) between a master
// driver and the register-file slave.
interface axi4_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, ARREADY, RDATA, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, ARREADY, RDATA, RVALID
  );

endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register-file slave: independent write and read FSMs over a
// word-addressed register array, with every register exposed to the fabric.
module axi4_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi4_lite_reg_slave_if.slave           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_COMMIT
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  aw_ok_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Word index of each address; any set bit above the index field puts it out of range.
  logic [ADDR_WIDTH-1:0] aw_word;
  logic [ADDR_WIDTH-1:0] ar_word;
  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_ok;
  logic                  ar_ok;

  assign aw_word = bus.AWADDR >> ADDR_LSB;
  assign ar_word = bus.ARADDR >> ADDR_LSB;
  assign aw_idx  = aw_word[IDX_W-1:0];
  assign ar_idx  = ar_word[IDX_W-1:0];
  assign aw_ok   = (aw_word[ADDR_WIDTH-1:IDX_W] == '0);
  assign ar_ok   = (ar_word[ADDR_WIDTH-1:IDX_W] == '0);

  // Readies come from state alone, forced low while reset is asserted.
  assign bus.AWREADY = !ARESET && (wr_state == WR_IDLE || wr_state == WR_WAIT_AW);
  assign bus.WREADY  = !ARESET && (wr_state == WR_IDLE || wr_state == WR_WAIT_W);
  assign bus.ARREADY = !ARESET && (rd_state == RD_IDLE);
  assign bus.RVALID  = (rd_state == RD_DATA);
  assign bus.RDATA   = rdata_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic enter_commit;
  logic [IDX_W-1:0] commit_idx;
  logic commit_ok;

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  // The address for the upcoming commit is either arriving now or was latched earlier.
  assign commit_idx = aw_hs ? aw_idx : aw_idx_q;
  assign commit_ok  = aw_hs ? aw_ok  : aw_ok_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves enter_commit unassigned (no latch).
    enter_commit = 1'b0;
    case (wr_state)
      WR_IDLE:    enter_commit = aw_hs && w_hs;
      WR_WAIT_W:  enter_commit = w_hs;
      WR_WAIT_AW: enter_commit = aw_hs;
      default:    enter_commit = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      w_data_q <= '0;
      wr_pulse <= '0;
      // NOTE: the register array is cleared on reset because software relies on a known zero state.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_pulse <= '0;
      if (enter_commit && commit_ok) begin
        wr_pulse[commit_idx] <= 1'b1;
      end
      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_ok_q  <= aw_ok;
      end
      if (w_hs) begin
        w_data_q <= bus.WDATA;
      end
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs && w_hs) wr_state <= WR_COMMIT;
          else if (aw_hs)    wr_state <= WR_WAIT_W;
          else if (w_hs)     wr_state <= WR_WAIT_AW;
        end
        WR_WAIT_W: begin
          if (w_hs) wr_state <= WR_COMMIT;
        end
        WR_WAIT_AW: begin
          if (aw_hs) wr_state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          if (aw_ok_q) begin
            regs[aw_idx_q] <= w_data_q;
          end
          wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // A read that coincides with the end of a commit samples the pre-commit register value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= ar_ok ? regs[ar_idx] : '0;
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.RREADY) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed plus randomized bench for axi4_lite_reg_slave, checked against an
// array model of the register file.
module tb_axi4_lite_reg_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;

  always #5 ACLK = ~ACLK;

  axi4_lite_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_reg_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bus     (bus),
    .reg_out (reg_out),
    .wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] model [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a / 4) < NR;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [31:0] a);
    return in_rng(a) ? model[a / 4] : '0;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check(tag, reg_out[i*DW +: DW], model[i]);
    end
  endtask

  // Write with each valid raised after its own delay; checks the commit cycle and the return to idle.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_delay, input int w_delay);
    bit aw_done = 0;
    bit w_done  = 0;
    bit saw_aw;
    bit saw_w;
    int c = 0;
    logic [NR-1:0] exp_pulse;
    bus.AWADDR = addr;
    bus.WDATA  = data;
    while (!(aw_done && w_done) && c < 30) begin
      if (!aw_done && c >= aw_delay) bus.AWVALID = 1'b1;
      if (!w_done && c >= w_delay)   bus.WVALID  = 1'b1;
      @(negedge ACLK);
      saw_aw = bus.AWVALID && bus.AWREADY;
      saw_w  = bus.WVALID && bus.WREADY;
      step();
      if (saw_aw) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (saw_w)  begin w_done  = 1; bus.WVALID  = 1'b0; end
      if (aw_done && !w_done) check("wait_w_ready", {bus.AWREADY, bus.WREADY}, 2'b01);
      if (w_done && !aw_done) check("wait_aw_ready", {bus.AWREADY, bus.WREADY}, 2'b10);
      c++;
    end
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    exp_pulse = '0;
    if (in_rng(addr)) exp_pulse[addr / 4] = 1'b1;
    check("commit_pulse", wr_pulse, exp_pulse);
    check("commit_ready", {bus.AWREADY, bus.WREADY}, 2'b00);
    step();
    if (in_rng(addr)) model[addr / 4] = data;
    check("pulse_clear", wr_pulse, '0);
    check("idle_ready", {bus.AWREADY, bus.WREADY}, 2'b11);
    check_regs("reg_out");
  endtask

  // Read with RREADY held low for 'hold' cycles after RVALID rises.
  task automatic axi_read(input logic [31:0] addr, input int hold);
    bit done = 0;
    int c = 0;
    logic [DW-1:0] exp;
    exp = model_read(addr);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    while (!done && c < 30) begin
      @(negedge ACLK);
      if (bus.ARREADY) done = 1;
      step();
      c++;
    end
    bus.ARVALID = 1'b0;
    check("ar_handshake", done, 1'b1);
    for (int i = 0; i < hold; i++) begin
      check("rvalid_hold", bus.RVALID, 1'b1);
      check("rdata_hold", bus.RDATA, exp);
      check("arready_busy", bus.ARREADY, 1'b0);
      step();
    end
    bus.RREADY = 1'b1;
    check("rvalid", bus.RVALID, 1'b1);
    check("rdata", bus.RDATA, exp);
    check("arready_busy", bus.ARREADY, 1'b0);
    step();
    bus.RREADY = 1'b0;
    check("rvalid_drop", bus.RVALID, 1'b0);
    check("arready_back", bus.ARREADY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [DW-1:0] old;
    ARESET      = 1'b1;
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WVALID  = 1'b0;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    step();
    check("rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    step();
    ARESET = 1'b0;
    #1;
    check("rel_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    check("rel_rvalid", bus.RVALID, 1'b0);
    check("rel_rdata", bus.RDATA, '0);
    check("rel_pulse", wr_pulse, '0);
    check_regs("rel_regs");

    // AW first, W three cycles later
    axi_write(32'h4, 32'hA5A5_0001, 0, 3);
    // W first then AW; then both together
    axi_write(32'h1C, 32'h1234_5678, 2, 0);
    axi_write(32'h0, 32'hCAFE_F00D, 0, 0);
    // Read held for five cycles
    axi_read(32'h4, 5);
    // Out of range write and read
    axi_write(32'h40, 32'hFFFF_FFFF, 0, 0);
    axi_read(32'h40, 0);
    axi_read(32'h1C, 1);

    // Read of reg2 at the same edge its commit ends returns the old value
    bus.AWADDR  = 32'h8;
    bus.WDATA   = 32'h0000_BEEF;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    check("coll_pulse", wr_pulse, 8'h04);
    bus.ARADDR  = 32'h8;
    bus.ARVALID = 1'b1;
    old = model[2];
    step();
    bus.ARVALID = 1'b0;
    model[2] = 32'h0000_BEEF;
    check("coll_rvalid", bus.RVALID, 1'b1);
    check("coll_rdata_old", bus.RDATA, old);
    check("coll_reg2", reg_out[2*DW +: DW], 32'h0000_BEEF);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    axi_read(32'h8, 0);

    // Randomized traffic, including byte offsets and far out-of-range addresses
    for (int n = 0; n < 40; n++) begin
      addr = $urandom_range(0, NR + 1) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h1000_0000;
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(addr, $urandom_range(0, 3));
    end

    // Reset while a read beat is pending and a write waits for data
    axi_write(32'h14, 32'h5555_AAAA, 0, 0);
    bus.ARADDR  = 32'h14;
    bus.ARVALID = 1'b1;
    bus.AWADDR  = 32'h10;
    bus.AWVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    bus.AWVALID = 1'b0;
    check("pre_rst_rvalid", bus.RVALID, 1'b1);
    check("pre_rst_wait_w", {bus.AWREADY, bus.WREADY}, 2'b01);
    #2;
    ARESET = 1'b1;
    #1;
    check("async_rvalid", bus.RVALID, 1'b0);
    check("async_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    check("async_rdata", bus.RDATA, '0);
    step();
    step();
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1;
    check("post_rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    check("post_rst_rvalid", bus.RVALID, 1'b0);
    check_regs("post_rst_regs");
    // The abandoned AW must not pair with a later W
    axi_write(32'h18, 32'h0BAD_CAFE, 0, 0);
    axi_read(32'h10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
